usr_shift_sequencer: RTL and testbench
======================================

# usr_shift_sequencer

Command-driven controller for the 8-bit universal shift register (USR). Accepts one operation at a time over a valid/ready handshake, drives the USR mode, serial and parallel inputs for the required number of cycles, and reports completion with the resulting register value. Sits between the host-side command source and the USR.

## Interface
Parameters:
- WIDTH, 8, USR data width
- CNT_W, 4, shift-count width; maximum count is 2^CNT_W-1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  enable; low freezes all state and forces usr_mode to hold
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_op  input  2  00 LOAD, 01 SHR, 10 SHL, 11 ROTR
- cmd_count  input  CNT_W  number of shift cycles; ignored for LOAD
- cmd_fill  input  1  serial fill bit for SHR/SHL
- cmd_data  input  WIDTH  parallel value for LOAD
- usr_mode  output  2  USR mode: 00 hold, 01 shift right (serial_in_left → MSB), 10 shift left (serial_in_right → LSB), 11 parallel load
- usr_sin_left  output  1  USR serial_in_left
- usr_sin_right  output  1  USR serial_in_right
- usr_pdata  output  WIDTH  USR parallel_in
- usr_q  input  WIDTH  current USR contents
- busy  output  1  high from acceptance until done
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  USR contents captured at completion

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, usr_mode=00. On cmd_valid&&cmd_ready, latch op/count/fill/data and go to LOAD (op 00), to SHIFT (shift op, count≠0), or to DONE (shift op, count=0).
- LOAD: usr_mode=11, usr_pdata=latched data; one cycle, then DONE.
- SHIFT: usr_mode=01 for SHR/ROTR, 10 for SHL; a counter loaded with count decrements on each SHIFT cycle; leave for DONE on the cycle the counter reads 1.
- Serial inputs: SHR sin_left=fill; SHL sin_right=fill; ROTR sin_left=usr_q[0] (combinational feedback). Unused serial input is 0.
- DONE: usr_mode=00, done=1, result<=usr_q; next cycle IDLE.
- busy=1 in LOAD, SHIFT and DONE.
- Commands presented while busy are not accepted; cmd_valid must be held until accepted.
- ena=0: state, counter and latched fields hold; usr_mode forced to 00; done and cmd_ready forced low; operation resumes unchanged when ena returns.
- Reset (at any time, including mid-shift): state IDLE, counter 0, usr_mode 00, usr_sin_left/right 0, usr_pdata 0, busy 0, done 0, result 0, cmd_ready 1 once rst_n is high. The USR contents themselves are not the sequencer's responsibility.

## Timing
- Accept at edge E0. LOAD: USR loads at E1; done high in the cycle after E1; cmd_ready returns after E2.
- Shift of count N≥1: USR shifts at E1..EN; done high in the cycle after EN with result valid the following cycle (captured at EN+1); cmd_ready high after EN+1.
- Count 0: done high in the cycle after E0; no USR change.
- Back-to-back: the minimum spacing between acceptances is N+2 cycles (LOAD counts as N=1).
- usr_mode, usr_pdata and busy are registered state decodes; usr_sin_left is combinational in ROTR only.

## Structure
- Shared package usr_pkg: MODE_HOLD/SHR/SHL/LOAD encodings, OP_LOAD/SHR/SHL/ROTR encodings, state enum; reused by the USR and the bench.
- One sub-module: usr_shift_counter (loadable down-counter with zero/one flags, enable input).

## Test plan
- Reset then LOAD 0xAA → usr_mode=11 for exactly one cycle, done pulse, result=0xAA, cmd_ready high 2 cycles after accept.
- From 0xAA, SHR count 2 fill 1 → two cycles of mode 01, result=0xEA, busy high for 3 cycles.
- From 0xEA, SHL count 3 fill 0 → result=0x50; from 0x81, ROTR count 1 → result=0xC0; ROTR count 8 → result unchanged.
- Count 0 SHR → done the cycle after accept, usr_mode stays 00, result equals prior contents.
- ena low for 3 cycles mid-way through SHR count 4 → exactly 4 shifts total, usr_mode=00 while ena low, done delayed by 3 cycles.
- rst_n asserted mid-SHIFT → outputs immediately at reset values, cmd_ready=1 after release, next LOAD 0x3C completes normally; cmd_valid held during busy is accepted only in IDLE.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its sequencer.
package usr_pkg;

  // USR mode encodings
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Command opcodes
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_LOAD  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  // Shift direction used by each shift opcode; rotate-right reuses the
  // right-shift mode with the LSB fed back into the MSB.
  function automatic logic [1:0] op_to_mode(input logic [1:0] op);
    logic [1:0] mode;
    case (op)
      OP_LOAD: mode = MODE_LOAD;
      OP_SHL:  mode = MODE_SHL;
      default: mode = MODE_SHR;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Loadable down-counter tracking how many shift cycles remain.
module usr_shift_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_zero,
  output logic             is_one
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (ena) begin
      if (load) begin
        count_d = load_val;
      end else if (dec && (count_q != '0)) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);
  assign is_one  = (count_q == CNT_W'(1));

endmodule

// File: rtl/usr_shift_sequencer.sv
// Command-driven controller that steps an 8-bit universal shift register
// through load, shift and rotate operations and reports the final value.
module usr_shift_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       usr_mode,
  output logic             usr_sin_left,
  output logic             usr_sin_right,
  output logic [WIDTH-1:0] usr_pdata,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state_q,  state_d;
  logic [1:0]       op_q,     op_d;
  logic             fill_q,   fill_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_is_zero;
  logic             cnt_is_one;

  usr_shift_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .load    (cnt_load),
    .load_val(cmd_count),
    .dec     (cnt_dec),
    .count   (cnt_value),
    .is_zero (cnt_is_zero),
    .is_one  (cnt_is_one)
  );

  // State transitions and command capture; everything freezes while ena is low.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fill_d   = fill_q;
    data_d   = data_q;
    result_d = result_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_d     = cmd_op;
            fill_d   = cmd_fill;
            data_d   = cmd_data;
            cnt_load = 1'b1;
            if (cmd_op == OP_LOAD) begin
              state_d = ST_LOAD;
            end else if (cmd_count == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end
        end
        ST_LOAD: begin
          state_d = ST_DONE;
        end
        ST_SHIFT: begin
          cnt_dec = 1'b1;
          if (cnt_is_one || cnt_is_zero) begin
            state_d = ST_DONE;
          end
        end
        default: begin
          result_d = usr_q;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state and latched command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LOAD;
      fill_q   <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

  // USR mode and serial inputs decoded from the registered state; rotate
  // feeds the current LSB straight back into the MSB.
  always_comb begin
    usr_mode      = MODE_HOLD;
    usr_sin_left  = 1'b0;
    usr_sin_right = 1'b0;
    if (ena) begin
      if (state_q == ST_LOAD) begin
        usr_mode = MODE_LOAD;
      end else if (state_q == ST_SHIFT) begin
        usr_mode = op_to_mode(op_q);
      end
    end
    if (state_q == ST_SHIFT) begin
      case (op_q)
        OP_SHR:  usr_sin_left  = fill_q;
        OP_SHL:  usr_sin_right = fill_q;
        OP_ROTR: usr_sin_left  = usr_q[0];
        default: usr_sin_left  = 1'b0;
      endcase
    end
  end

  assign cmd_ready = ena && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = ena && (state_q == ST_DONE);
  assign usr_pdata = data_q;
  assign result    = result_q;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer driving a behavioural USR model.
module tb_usr_shift_sequencer;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_count;
  logic       cmd_fill;
  logic [7:0] cmd_data;
  logic [1:0] usr_mode;
  logic       usr_sin_left;
  logic       usr_sin_right;
  logic [7:0] usr_pdata;
  logic [7:0] usr_q = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] result;

  int testsRun    = 0;
  int testsFailed = 0;

  usr_shift_sequencer #(
    .WIDTH(8),
    .CNT_W(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_count    (cmd_count),
    .cmd_fill     (cmd_fill),
    .cmd_data     (cmd_data),
    .usr_mode     (usr_mode),
    .usr_sin_left (usr_sin_left),
    .usr_sin_right(usr_sin_right),
    .usr_pdata    (usr_pdata),
    .usr_q        (usr_q),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  always #5 clk = ~clk;

  // Behavioural universal shift register driven by the sequencer.
  always @(posedge clk) begin
    case (usr_mode)
      MODE_SHR:  usr_q <= {usr_sin_left, usr_q[7:1]};
      MODE_SHL:  usr_q <= {usr_q[6:0], usr_sin_right};
      MODE_LOAD: usr_q <= usr_pdata;
      default:   usr_q <= usr_q;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present a command at a falling edge, hold it until accepted, then drop it.
  // Returns at the first falling edge after the accepting clock edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] cnt,
                               input logic fill, input logic [7:0] data);
    int n;
    cmd_op    = op;
    cmd_count = cnt;
    cmd_fill  = fill;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count falling edges until done is seen, bounded.
  task automatic waitDone(input string tag, input int expCycles);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(n), 32'(expCycles));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_LOAD;
    cmd_count = 4'd0;
    cmd_fill  = 1'b0;
    cmd_data  = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy",   32'(busy),      32'd0);
    checkOutput("rst_done",   32'(done),      32'd0);
    checkOutput("rst_mode",   32'(usr_mode),  32'd0);
    checkOutput("rst_result", 32'(result),    32'h00);
    checkOutput("rst_pdata",  32'(usr_pdata), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready",  32'(cmd_ready), 32'd1);

    // LOAD 0xAA
    applyStimulus(OP_LOAD, 4'd0, 1'b0, 8'hAA);
    checkOutput("load_mode",   32'(usr_mode),  32'd3);
    checkOutput("load_busy",   32'(busy),      32'd1);
    checkOutput("load_pdata",  32'(usr_pdata), 32'hAA);
    checkOutput("load_ready0", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("load_mode_off", 32'(usr_mode), 32'd0);
    checkOutput("load_done",     32'(done),     32'd1);
    checkOutput("load_usr_q",    32'(usr_q),    32'hAA);
    @(negedge clk);
    checkOutput("load_done_pulse", 32'(done),      32'd0);
    checkOutput("load_ready1",     32'(cmd_ready), 32'd1);
    checkOutput("load_result",     32'(result),    32'hAA);

    // SHR count 2 fill 1: AA -> D5 -> EA
    applyStimulus(OP_SHR, 4'd2, 1'b1, 8'h00);
    checkOutput("shr_mode1", 32'(usr_mode),     32'd1);
    checkOutput("shr_sinl",  32'(usr_sin_left), 32'd1);
    @(negedge clk);
    checkOutput("shr_mode2", 32'(usr_mode), 32'd1);
    checkOutput("shr_mid_q", 32'(usr_q),    32'hD5);
    @(negedge clk);
    checkOutput("shr_done",  32'(done),     32'd1);
    checkOutput("shr_busy3", 32'(busy),     32'd1);
    checkOutput("shr_mode3", 32'(usr_mode), 32'd0);
    @(negedge clk);
    checkOutput("shr_result", 32'(result), 32'hEA);
    checkOutput("shr_idle",   32'(busy),   32'd0);

    // SHL count 3 fill 0: EA -> D4 -> A8 -> 50
    applyStimulus(OP_SHL, 4'd3, 1'b0, 8'h00);
    checkOutput("shl_mode", 32'(usr_mode), 32'd2);
    waitDone("shl_done_lat", 3);
    @(negedge clk);
    checkOutput("shl_result", 32'(result), 32'h50);

    // LOAD 0x81 then ROTR 1 -> C0, ROTR 8 -> C0
    applyStimulus(OP_LOAD, 4'd0, 1'b0, 8'h81);
    waitDone("load81_done_lat", 1);
    @(negedge clk);
    checkOutput("load81_result", 32'(result), 32'h81);
    applyStimulus(OP_ROTR, 4'd1, 1'b0, 8'h00);
    checkOutput("rotr_mode", 32'(usr_mode),     32'd1);
    checkOutput("rotr_sinl", 32'(usr_sin_left), 32'd1);
    waitDone("rotr1_done_lat", 1);
    @(negedge clk);
    checkOutput("rotr1_result", 32'(result), 32'hC0);
    applyStimulus(OP_ROTR, 4'd8, 1'b0, 8'h00);
    waitDone("rotr8_done_lat", 8);
    @(negedge clk);
    checkOutput("rotr8_result", 32'(result), 32'hC0);

    // Count 0 SHR: immediate done, no USR change
    applyStimulus(OP_SHR, 4'd0, 1'b1, 8'h00);
    checkOutput("cnt0_done", 32'(done),     32'd1);
    checkOutput("cnt0_mode", 32'(usr_mode), 32'd0);
    @(negedge clk);
    checkOutput("cnt0_result", 32'(result), 32'hC0);

    // SHR count 4 fill 0 with ena low for 3 cycles: C0 -> 60 (pause) -> 30 -> 18 -> 0C
    applyStimulus(OP_SHR, 4'd4, 1'b0, 8'h00);
    checkOutput("ena_mode_run", 32'(usr_mode), 32'd1);
    @(negedge clk);
    ena = 1'b0;
    #1;
    checkOutput("ena_mode_hold",  32'(usr_mode),  32'd0);
    checkOutput("ena_ready_low",  32'(cmd_ready), 32'd0);
    checkOutput("ena_busy_kept",  32'(busy),      32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ena_mode_hold3", 32'(usr_mode), 32'd0);
    checkOutput("ena_q_frozen",   32'(usr_q),    32'h60);
    @(negedge clk);
    ena = 1'b1;
    #1;
    checkOutput("ena_mode_resume", 32'(usr_mode), 32'd1);
    waitDone("ena_done_lat", 3);
    @(negedge clk);
    checkOutput("ena_result", 32'(result), 32'h0C);

    // Reset mid-shift
    applyStimulus(OP_SHL, 4'd5, 1'b1, 8'h00);
    checkOutput("mid_mode", 32'(usr_mode),      32'd2);
    checkOutput("mid_sinr", 32'(usr_sin_right), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_mode",   32'(usr_mode),      32'd0);
    checkOutput("mid_rst_busy",   32'(busy),          32'd0);
    checkOutput("mid_rst_result", 32'(result),        32'h00);
    checkOutput("mid_rst_sinr",   32'(usr_sin_right), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rel_ready", 32'(cmd_ready), 32'd1);

    // LOAD 0x3C with a second command held during busy
    applyStimulus(OP_LOAD, 4'd0, 1'b0, 8'h3C);
    cmd_op    = OP_SHR;
    cmd_count = 4'd1;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    checkOutput("hold_ready_c1", 32'(cmd_ready), 32'd0);
    checkOutput("hold_mode_c1",  32'(usr_mode),  32'd3);
    @(negedge clk);
    checkOutput("hold_done_c2",  32'(done),      32'd1);
    checkOutput("hold_ready_c2", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    checkOutput("hold_ready_c3", 32'(cmd_ready), 32'd1);
    checkOutput("hold_result",   32'(result),    32'h3C);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("hold_acc_mode", 32'(usr_mode), 32'd1);
    checkOutput("hold_acc_busy", 32'(busy),     32'd1);
    waitDone("hold_done_lat", 1);
    @(negedge clk);
    checkOutput("hold_shr_result", 32'(result), 32'h1E);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
